// File: rtl/div_unit.sv
// div_unit -- multi-cycle restoring radix-2 divider for DIV/DIVU in the
// execute stage of the 5-stage MIPS pipeline.
//
// The operand magnitudes are divided one quotient bit per cycle. The
// quotient and remainder are then sign-corrected and registered into
// lo_E/hi_E on entry to DONE. alu_ready_E goes to the hazard unit. While it
// is low the execute stage stalls and the memory stage is flushed.
//
// Optional build macro:
//   DIV_EARLY_EXIT_EN - skip the leading-zero bits of |dividend|. The
//                       dividend is pre-shifted and fewer iterations are
//                       run. Results are identical; only latency changes.
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   start_E      DIV/DIVU present in execute stage
//   signed_E     1 = DIV (signed), 0 = DIVU
//   a_E, b_E     dividend / divisor (sampled only in the start cycle)
//   cancel       abort an in-flight division, suppress start in IDLE
//   alu_ready_E  0 = execute stage must stall (combinational)
//   busy         registered, 1 while a division is iterating
//   hi_E         remainder of last completed division
//   lo_E         quotient of last completed division
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_E,
  input  logic             signed_E,
  input  logic [WIDTH-1:0] a_E,
  input  logic [WIDTH-1:0] b_E,
  input  logic             cancel,
  output logic             alu_ready_E,
  output logic             busy,
  output logic [WIDTH-1:0] hi_E,
  output logic [WIDTH-1:0] lo_E
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, quo, divisor, a_raw;
  logic             neg_q, neg_r, dz;

  logic             start_ok;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [CW-1:0]    load_cnt;
  logic [WIDTH-1:0] load_quo;
  logic [WIDTH:0]   shifted, diff;
  logic             ge;
  logic [WIDTH-1:0] rem_step, quo_step;
  logic [WIDTH-1:0] q_fix, r_fix;
  logic             last_step;

`ifdef DIV_EARLY_EXIT_EN
  logic [CW-1:0]    lz;

  // Leading-zero count; WIDTH for an all-zero value.
  function automatic logic [CW-1:0] lead_zeros(input logic [WIDTH-1:0] v);
    lead_zeros = CW'(WIDTH);
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (v[i]) lead_zeros = CW'(WIDTH - 1 - i);
    end
  endfunction
`endif

  // Operand capture: magnitudes, sign flags and iteration count.
  always_comb begin
    start_ok = start_E & ~cancel;
    a_neg    = signed_E & a_E[WIDTH-1];
    b_neg    = signed_E & b_E[WIDTH-1];
    a_mag    = a_neg ? (~a_E + 1'b1) : a_E;
    b_mag    = b_neg ? (~b_E + 1'b1) : b_E;
`ifdef DIV_EARLY_EXIT_EN
    lz = lead_zeros(a_mag);
    // Leading zeros of the dividend only ever yield zero quotient bits with
    // rem staying 0, so they are skipped. The quotient ends up in the low
    // WIDTH-lz bits, and the zeros shifted in fill the rest.
    if ((a_mag == '0) || (b_E == '0)) begin
      load_cnt = CW'(1);
      load_quo = a_mag;
    end else begin
      load_cnt = CW'(WIDTH) - lz;
      load_quo = a_mag << lz;
    end
`else
    load_cnt = CW'(WIDTH);
    load_quo = a_mag;
`endif
  end

  // One restoring step. The compare/subtract is WIDTH+1 bits wide because
  // the shifted partial remainder can exceed WIDTH bits.
  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    diff     = shifted - {1'b0, divisor};
    ge       = (shifted >= {1'b0, divisor});
    rem_step = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_step = {quo[WIDTH-2:0], ge};
    // Divide-by-zero bypasses sign correction entirely.
    q_fix    = dz ? '1    : (neg_q ? (~quo_step + 1'b1) : quo_step);
    r_fix    = dz ? a_raw : (neg_r ? (~rem_step + 1'b1) : rem_step);
    last_step = (cnt == CW'(1));
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_ok) state_nxt = BUSY;
      BUSY: begin
        if (cancel)         state_nxt = IDLE;
        else if (last_step) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Ready falls in the very cycle start arrives so the hazard unit can stall
  // it. It is forced high while reset is asserted.
  always_comb begin
    alu_ready_E = ~rst_n |
                  ~(((state == IDLE) & start_ok) | (state == BUSY));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      divisor <= '0;
      a_raw   <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      dz      <= 1'b0;
      hi_E    <= '0;
      lo_E    <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == BUSY);
      case (state)
        IDLE: begin
          if (start_ok) begin
            cnt     <= load_cnt;
            rem     <= '0;
            quo     <= load_quo;
            divisor <= b_mag;
            a_raw   <= a_E;
            neg_q   <= a_neg ^ b_neg;
            neg_r   <= a_neg;
            dz      <= (b_E == '0);
          end
        end
        BUSY: begin
          if (!cancel) begin
            rem <= rem_step;
            quo <= quo_step;
            cnt <= cnt - 1'b1;
            // Results land on the edge that enters DONE.
            if (last_step) begin
              hi_E <= r_fix;
              lo_E <= q_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit -- self-checking bench for div_unit. A transaction-level model
// (reference arithmetic plus a stall-cycle countdown) is compared against all
// outputs on every falling edge. Directed operations pin literal results and
// latencies; a randomized phase exercises back-to-back, cancel and corner
// operands.
module tb_div_unit;
  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start_E, signed_E, cancel;
  logic [WIDTH-1:0] a_E, b_E;
  logic             alu_ready_E, busy;
  logic [WIDTH-1:0] hi_E, lo_E;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  div_unit #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_E    (start_E),
    .signed_E   (signed_E),
    .a_E        (a_E),
    .b_E        (b_E),
    .cancel     (cancel),
    .alu_ready_E(alu_ready_E),
    .busy       (busy),
    .hi_E       (hi_E),
    .lo_E       (lo_E)
  );

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: {hi, lo} for one division.
  function automatic logic [2*WIDTH-1:0] ref_div(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic s);
    longint sa, sb, q, r;
    if (b == '0) return {a, {WIDTH{1'b1}}};
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'(a);
      sb = longint'(b);
    end
    q = sa / sb;
    r = sa % sb;
    return {r[WIDTH-1:0], q[WIDTH-1:0]};
  endfunction

  // Number of stall cycles after the start cycle.
  function automatic int unsigned iters(input logic [WIDTH-1:0] a,
                                        input logic [WIDTH-1:0] b,
                                        input logic s);
`ifdef DIV_EARLY_EXIT_EN
    logic [WIDTH-1:0] mag;
    mag = (s && a[WIDTH-1]) ? (~a + 1'b1) : a;
    if (mag == '0 || b == '0) return 1;
    for (int i = WIDTH - 1; i >= 0; i--) if (mag[i]) return i + 1;
    return 1;
`else
    return WIDTH;
`endif
  endfunction

  // Transaction-level model.
  int unsigned          m_left = 0;
  bit                   m_done = 1'b0;
  logic [WIDTH-1:0]     m_hi = '0, m_lo = '0;
  logic [2*WIDTH-1:0]   p_res = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0;
      m_done = 1'b0;
      m_hi   = '0;
      m_lo   = '0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_left != 0) begin
      if (cancel) m_left = 0;
      else begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1'b1;
          {m_hi, m_lo} = p_res;
        end
      end
    end else if (start_E && !cancel) begin
      m_left = iters(a_E, b_E, signed_E);
      p_res  = ref_div(a_E, b_E, signed_E);
    end
  end

  // Compare process.
  always @(negedge clk) begin
    logic exp_ready;
    exp_ready = !rst_n || !((m_left != 0) || (!m_done && start_E && !cancel));
    check("model_ready", WIDTH'(alu_ready_E), WIDTH'(exp_ready));
    check("model_busy",  WIDTH'(busy),        WIDTH'(m_left != 0));
    check("model_hi",    hi_E, m_hi);
    check("model_lo",    lo_E, m_lo);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered at posedge+1 of offset n; returns at the negedge of the first
  // ready-high cycle, with n holding its offset.
  task automatic wait_done(inout int n);
    while (n < 300) begin
      @(negedge clk);
      if (alu_ready_E) return;
      tick();
      n++;
    end
  endtask

  task automatic op(input string name, input logic [WIDTH-1:0] a,
                    input logic [WIDTH-1:0] b, input logic s,
                    input int lat_full, input int lat_early,
                    input logic [WIDTH-1:0] elo, input logic [WIDTH-1:0] ehi);
    int n;
    int lat;
`ifdef DIV_EARLY_EXIT_EN
    lat = lat_early;
`else
    lat = lat_full;
`endif
    a_E = a; b_E = b; signed_E = s; start_E = 1'b1;
    tick();
    start_E = 1'b0; a_E = $urandom; b_E = $urandom; signed_E = ~s;
    n = 1;
    wait_done(n);
    check({name, "_lat"}, WIDTH'(n), WIDTH'(lat));
    check({name, "_lo"}, lo_E, elo);
    check({name, "_hi"}, hi_E, ehi);
    tick();
  endtask

  function automatic logic [WIDTH-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return WIDTH'($urandom_range(0, 15));
      4:       return $urandom >> $urandom_range(0, 31);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    rst_n = 1'b1; start_E = 1'b0; signed_E = 1'b0; cancel = 1'b0;
    a_E = '0; b_E = '0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("reset_ready", WIDTH'(alu_ready_E), WIDTH'(1));
    check("reset_busy",  WIDTH'(busy), '0);
    check("reset_hi",    hi_E, '0);
    check("reset_lo",    lo_E, '0);
    tick();
    rst_n = 1'b1;
    tick();

    op("divu_100_7", 32'd100, 32'd7, 1'b0, 33, 8, 32'd14, 32'd2);

    // Cancel mid-flight: results keep the previous 14 / 2.
    a_E = 32'hFFFF_0000; b_E = 32'd3; signed_E = 1'b0; start_E = 1'b1;
    tick();
    start_E = 1'b0;
    repeat (9) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    @(negedge clk);
    check("cancel_ready", WIDTH'(alu_ready_E), WIDTH'(1));
    check("cancel_busy",  WIDTH'(busy), '0);
    check("cancel_lo",    lo_E, 32'd14);
    check("cancel_hi",    hi_E, 32'd2);
    tick();

    op("div_m7_2",   32'hFFFF_FFF9, 32'd2,         1'b1, 33, 4,  32'hFFFF_FFFD, 32'hFFFF_FFFF);
    op("div_7_m2",   32'd7,         32'hFFFF_FFFE, 1'b1, 33, 4,  32'hFFFF_FFFD, 32'd1);
    op("divu_5_0",   32'd5,         32'd0,         1'b0, 33, 2,  32'hFFFF_FFFF, 32'd5);
    op("div_5_0",    32'd5,         32'd0,         1'b1, 33, 2,  32'hFFFF_FFFF, 32'd5);
    op("div_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 33, 33, 32'h8000_0000, 32'd0);
    op("divu_3_1",   32'd3,         32'd1,         1'b0, 33, 3,  32'd3,         32'd0);
    op("divu_0_5",   32'd0,         32'd5,         1'b0, 33, 2,  32'd0,         32'd0);

    // Back-to-back with start held through the first DONE.
    a_E = 32'd9; b_E = 32'd3; signed_E = 1'b0; start_E = 1'b1;
    tick();
    n = 1;
    wait_done(n);
`ifdef DIV_EARLY_EXIT_EN
    check("b2b_lat1", WIDTH'(n), WIDTH'(5));
`else
    check("b2b_lat1", WIDTH'(n), WIDTH'(33));
`endif
    check("b2b_lo1", lo_E, 32'd3);
    check("b2b_hi1", hi_E, 32'd0);
    tick();
    n++;
    a_E = 32'd10; b_E = 32'd4;
    tick();
    n++;
    start_E = 1'b0;
    wait_done(n);
`ifdef DIV_EARLY_EXIT_EN
    check("b2b_lat2", WIDTH'(n), WIDTH'(11));
`else
    check("b2b_lat2", WIDTH'(n), WIDTH'(67));
`endif
    check("b2b_lo2", lo_E, 32'd2);
    check("b2b_hi2", hi_E, 32'd2);
    tick();

    // Reset in the middle of an operation.
    a_E = 32'hFFFF_0000; b_E = 32'd5; signed_E = 1'b0; start_E = 1'b1;
    tick();
    start_E = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    start_E = 1'b1;
    #1;
    check("rst_ready", WIDTH'(alu_ready_E), WIDTH'(1));
    check("rst_busy",  WIDTH'(busy), '0);
    check("rst_hi",    hi_E, '0);
    check("rst_lo",    lo_E, '0);
    tick();
    start_E = 1'b0;
    rst_n = 1'b1;
    tick();

    // Randomized phase, checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      start_E  = ($urandom_range(0, 3) != 0);
      signed_E = $urandom_range(0, 1);
      cancel   = ($urandom_range(0, 63) == 0);
      a_E      = pick_operand();
      b_E      = pick_operand();
      tick();
    end
    start_E = 1'b0;
    cancel  = 1'b0;
    repeat (40) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
